reg_access_arbiter: RTL and testbench

REG_ACCESS_ARBITER -- requirements
Module: reg_access_arbiter

---
 rtl/reg_access_arbiter_if.sv | 43 ++++
 rtl/reg_access_arbiter.sv | 135 +++++++++++++
 tb/tb_reg_access_arbiter.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/reg_access_arbiter_if.sv
// Bundle between two register requesters, the arbiter and the shared register port.
// The slave modport is the arbiter's view; the master modport is the surrounding environment's view.
interface reg_access_arbiter_if;
    logic        m0_req_i;
    logic        m1_req_i;
    logic        m0_wr_i;
    logic        m1_wr_i;
    logic [2:0]  m0_addr_i;
    logic [2:0]  m1_addr_i;
    logic [15:0] m0_wdata_i;
    logic [15:0] m1_wdata_i;
    logic        m0_gnt_o;
    logic        m1_gnt_o;
    logic        m0_done_o;
    logic        m1_done_o;
    logic [15:0] m0_rdata_o;
    logic [15:0] m1_rdata_o;
    logic        err_o;
    logic        acc_en_o;
    logic        wr_en_o;
    logic [2:0]  addr_o;
    logic [15:0] wdata_o;
    logic [15:0] rdata_i;
    logic        busy_o;

    modport slave (
        input  m0_req_i, m1_req_i, m0_wr_i, m1_wr_i,
        input  m0_addr_i, m1_addr_i, m0_wdata_i, m1_wdata_i,
        input  rdata_i,
        output m0_gnt_o, m1_gnt_o, m0_done_o, m1_done_o,
        output m0_rdata_o, m1_rdata_o, err_o,
        output acc_en_o, wr_en_o, addr_o, wdata_o, busy_o
    );

    modport master (
        output m0_req_i, m1_req_i, m0_wr_i, m1_wr_i,
        output m0_addr_i, m1_addr_i, m0_wdata_i, m1_wdata_i,
        output rdata_i,
        input  m0_gnt_o, m1_gnt_o, m0_done_o, m1_done_o,
        input  m0_rdata_o, m1_rdata_o, err_o,
        input  acc_en_o, wr_en_o, addr_o, wdata_o, busy_o
    );
endinterface

// File: rtl/reg_access_arbiter.sv
// Two-requester register access arbiter: picks one requester at a time and runs
// its command through IDLE -> ACCESS -> RESP on the shared register port.
module reg_access_arbiter #(
    parameter bit RR_EN = 1'b1
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    reg_access_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    state_e      state_q;
    logic        lastM1_q;
    logic        winM1_q;
    logic        wr_q;
    logic        reject_q;
    logic        accEn_q;
    logic        wrEn_q;
    logic [2:0]  addrOut_q;
    logic [15:0] wdataOut_q;
    logic        m0Done_q;
    logic        m1Done_q;
    logic [15:0] m0Rdata_q;
    logic [15:0] m1Rdata_q;
    logic        err_q;
    logic        busy_q;

    logic        anyReq;
    logic        winM1_d;
    logic        wr_d;
    logic [2:0]  addr_d;
    logic [15:0] wdata_d;
    logic        reject_d;
    logic [15:0] capData;

    // Winner selection and command decode for the request seen this IDLE cycle.
    always_comb begin
        anyReq  = bus.m0_req_i | bus.m1_req_i;
        winM1_d = 1'b0;
        if (bus.m0_req_i && bus.m1_req_i) begin
            winM1_d = RR_EN ? ~lastM1_q : 1'b0;
        end else begin
            winM1_d = bus.m1_req_i;
        end
        wr_d     = winM1_d ? bus.m1_wr_i    : bus.m0_wr_i;
        addr_d   = winM1_d ? bus.m1_addr_i  : bus.m0_addr_i;
        wdata_d  = winM1_d ? bus.m1_wdata_i : bus.m0_wdata_i;
        // 3'b111 is unmapped; 3'b100 and 3'b110 are read-only.
        reject_d = (addr_d == 3'b111) ||
                   (wr_d && ((addr_d == 3'b100) || (addr_d == 3'b110)));
        capData  = (wr_q || reject_q) ? 16'h0000 : bus.rdata_i;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= IDLE;
            lastM1_q   <= 1'b1;
            winM1_q    <= 1'b0;
            wr_q       <= 1'b0;
            reject_q   <= 1'b0;
            accEn_q    <= 1'b0;
            wrEn_q     <= 1'b0;
            addrOut_q  <= 3'b000;
            wdataOut_q <= 16'h0000;
            m0Done_q   <= 1'b0;
            m1Done_q   <= 1'b0;
            m0Rdata_q  <= 16'h0000;
            m1Rdata_q  <= 16'h0000;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (anyReq) begin
                        state_q    <= ACCESS;
                        busy_q     <= 1'b1;
                        lastM1_q   <= winM1_d;
                        winM1_q    <= winM1_d;
                        wr_q       <= wr_d;
                        reject_q   <= reject_d;
                        accEn_q    <= ~reject_d;
                        wrEn_q     <= wr_d & ~reject_d;
                        addrOut_q  <= reject_d ? 3'b000 : addr_d;
                        wdataOut_q <= reject_d ? 16'h0000 : wdata_d;
                    end
                end
                ACCESS: begin
                    state_q    <= RESP;
                    accEn_q    <= 1'b0;
                    wrEn_q     <= 1'b0;
                    addrOut_q  <= 3'b000;
                    wdataOut_q <= 16'h0000;
                    m0Done_q   <= ~winM1_q;
                    m1Done_q   <= winM1_q;
                    m0Rdata_q  <= winM1_q ? 16'h0000 : capData;
                    m1Rdata_q  <= winM1_q ? capData : 16'h0000;
                    err_q      <= reject_q;
                end
                RESP: begin
                    state_q   <= IDLE;
                    busy_q    <= 1'b0;
                    m0Done_q  <= 1'b0;
                    m1Done_q  <= 1'b0;
                    m0Rdata_q <= 16'h0000;
                    m1Rdata_q <= 16'h0000;
                    err_q     <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Grant is decoded in the sampling cycle itself and masked while reset is held.
    assign bus.m0_gnt_o   = rstn_i && (state_q == IDLE) && anyReq && !winM1_d;
    assign bus.m1_gnt_o   = rstn_i && (state_q == IDLE) && anyReq && winM1_d;
    assign bus.m0_done_o  = m0Done_q;
    assign bus.m1_done_o  = m1Done_q;
    assign bus.m0_rdata_o = m0Rdata_q;
    assign bus.m1_rdata_o = m1Rdata_q;
    assign bus.err_o      = err_q;
    assign bus.acc_en_o   = accEn_q;
    assign bus.wr_en_o    = wrEn_q;
    assign bus.addr_o     = addrOut_q;
    assign bus.wdata_o    = wdataOut_q;
    assign bus.busy_o     = busy_q;

endmodule

// File: tb/tb_reg_access_arbiter.sv
// Randomized scoreboard bench: the stimulus side predicts each transaction from the
// arbitration and reject rules, a monitor pops and compares as the arbiter responds.
module tb_reg_access_arbiter;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    reg_access_arbiter_if rr ();
    reg_access_arbiter_if fp ();

    reg_access_arbiter #(.RR_EN(1'b1)) dutRr (.clk_i(clk), .rstn_i(rstn), .bus(rr));
    reg_access_arbiter #(.RR_EN(1'b0)) dutFp (.clk_i(clk), .rstn_i(rstn), .bus(fp));

    typedef struct packed {
        logic        who;
        logic        wr;
        logic [2:0]  addr;
        logic [15:0] wdata;
        logic        rej;
        logic [15:0] rdata;
    } txn_t;

    txn_t        gntQ[$];
    int          gntTimes[$];
    txn_t        cur;
    int          phase    = 0;
    int          passCnt  = 0;
    int          totalCnt = 0;
    int          cycleCnt = 0;
    int          fpGrants = 0;
    logic [1:0]  gntSeen;
    logic        pend[2];
    logic        pWr[2];
    logic [2:0]  pAddr[2];
    logic [15:0] pWdata[2];
    logic        lastM1;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic isReject(input logic wr, input logic [2:0] addr);
        return (addr == 3'd7) || (wr && (addr == 3'd4 || addr == 3'd6));
    endfunction

    function automatic logic [20:0] portVec();
        return {rr.acc_en_o, rr.wr_en_o, rr.addr_o, rr.wdata_o};
    endfunction

    function automatic logic [63:0] rrOutputs();
        return {5'd0, rr.m0_gnt_o, rr.m1_gnt_o, rr.m0_done_o, rr.m1_done_o, rr.m0_rdata_o,
                rr.m1_rdata_o, rr.err_o, rr.acc_en_o, rr.wr_en_o, rr.addr_o, rr.wdata_o, rr.busy_o};
    endfunction

    // One arbitration slot, entered one time unit after a clock edge with the arbiter idle.
    task automatic applyStimulus(input logic want0, input logic wr0, input logic [2:0] a0, input logic [15:0] d0,
                                 input logic want1, input logic wr1, input logic [2:0] a1, input logic [15:0] d1,
                                 input logic [15:0] rd, input logic late, input logic abort);
        txn_t t;
        logic w;
        if (want0 && !pend[0]) begin pend[0] = 1'b1; pWr[0] = wr0; pAddr[0] = a0; pWdata[0] = d0; end
        if (want1 && !pend[1]) begin pend[1] = 1'b1; pWr[1] = wr1; pAddr[1] = a1; pWdata[1] = d1; end
        rr.m0_req_i   = pend[0];
        rr.m0_wr_i    = pend[0] ? pWr[0]    : 1'($urandom);
        rr.m0_addr_i  = pend[0] ? pAddr[0]  : 3'($urandom);
        rr.m0_wdata_i = pend[0] ? pWdata[0] : 16'($urandom);
        rr.m1_req_i   = pend[1];
        rr.m1_wr_i    = pend[1] ? pWr[1]    : 1'($urandom);
        rr.m1_addr_i  = pend[1] ? pAddr[1]  : 3'($urandom);
        rr.m1_wdata_i = pend[1] ? pWdata[1] : 16'($urandom);
        rr.rdata_i    = rd;
        if (!pend[0] && !pend[1]) begin
            @(posedge clk); #1;
            return;
        end
        if (pend[0] && pend[1]) w = lastM1 ? 1'b0 : 1'b1;
        else w = pend[1];
        lastM1  = w;
        t.who   = w;
        t.wr    = pWr[w];
        t.addr  = pAddr[w];
        t.wdata = pWdata[w];
        t.rej   = isReject(t.wr, t.addr);
        t.rdata = (!t.wr && !t.rej) ? rd : 16'h0000;
        gntQ.push_back(t);
        pend[w] = 1'b0;
        @(posedge clk); #1;
        if (abort) begin
            rstn = 1'b0;
            #1;
            checkOutput("abortZero", rrOutputs(), 64'd0);
            pend[0] = 1'b0;
            pend[1] = 1'b0;
            lastM1  = 1'b1;
            rr.m0_req_i = 1'b0;
            rr.m1_req_i = 1'b0;
            @(posedge clk); #1;
            rstn = 1'b1;
            return;
        end
        if (late) begin
            if (w) begin
                rr.m1_addr_i ^= 3'b001; rr.m1_wdata_i = ~rr.m1_wdata_i; rr.m1_wr_i = ~rr.m1_wr_i;
            end else begin
                rr.m0_addr_i ^= 3'b001; rr.m0_wdata_i = ~rr.m0_wdata_i; rr.m0_wr_i = ~rr.m0_wr_i;
            end
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    // Monitor: pops the predicted transaction on each grant and follows it to done.
    always @(negedge clk) begin
        if (!rstn) begin
            phase = 0;
        end else begin
            gntSeen = {rr.m1_gnt_o, rr.m0_gnt_o};
            case (phase)
                0: begin
                    checkOutput("idleDone", {61'd0, rr.m1_done_o, rr.m0_done_o, rr.err_o}, 64'd0);
                    checkOutput("idleRdata", {32'd0, rr.m1_rdata_o, rr.m0_rdata_o}, 64'd0);
                    checkOutput("idlePort", {43'd0, portVec()}, 64'd0);
                    checkOutput("idleBusy", {63'd0, rr.busy_o}, 64'd0);
                    if (gntQ.size() > 0) begin
                        cur = gntQ.pop_front();
                        checkOutput("grant", {62'd0, gntSeen}, cur.who ? 64'd2 : 64'd1);
                        if (gntSeen != 2'b00) begin
                            phase = 1;
                            gntTimes.push_back(cycleCnt);
                        end
                    end else begin
                        checkOutput("noGrant", {62'd0, gntSeen}, 64'd0);
                    end
                end
                1: begin
                    checkOutput("accessPort", {43'd0, portVec()},
                                cur.rej ? 64'd0 : {43'd0, 1'b1, cur.wr, cur.addr, cur.wdata});
                    checkOutput("accessQuiet", {60'd0, gntSeen, rr.m1_done_o, rr.m0_done_o}, 64'd0);
                    checkOutput("accessBusy", {63'd0, rr.busy_o}, 64'd1);
                    phase = 2;
                end
                default: begin
                    checkOutput("respDone", {62'd0, rr.m1_done_o, rr.m0_done_o}, cur.who ? 64'd2 : 64'd1);
                    checkOutput("respErr", {63'd0, rr.err_o}, {63'd0, cur.rej});
                    checkOutput("respRdata", {32'd0, rr.m1_rdata_o, rr.m0_rdata_o},
                                cur.who ? {32'd0, cur.rdata, 16'd0} : {48'd0, cur.rdata});
                    checkOutput("respPort", {43'd0, portVec()}, 64'd0);
                    checkOutput("respBusy", {63'd0, rr.busy_o}, 64'd1);
                    phase = 0;
                end
            endcase
        end
    end

    initial begin
        pend[0] = 1'b0; pend[1] = 1'b0; lastM1 = 1'b1;
        rr.m0_req_i = 1'b1; rr.m1_req_i = 1'b1; rr.m0_wr_i = 1'b0; rr.m1_wr_i = 1'b0;
        rr.m0_addr_i = 3'd0; rr.m1_addr_i = 3'd0; rr.m0_wdata_i = 16'h0; rr.m1_wdata_i = 16'h0;
        rr.rdata_i = 16'h0;
        fp.m0_req_i = 1'b0; fp.m1_req_i = 1'b0; fp.m0_wr_i = 1'b0; fp.m1_wr_i = 1'b0;
        fp.m0_addr_i = 3'd0; fp.m1_addr_i = 3'd0; fp.m0_wdata_i = 16'h0; fp.m1_wdata_i = 16'h0;
        fp.rdata_i = 16'h0;
        #12;
        checkOutput("resetOutputs", rrOutputs(), 64'd0);
        rr.m0_req_i = 1'b0; rr.m1_req_i = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;

        $display("[TB] contention, round robin");
        gntTimes.delete();
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b1, 1'($urandom), 3'($urandom), 16'($urandom),
                          1'b1, 1'($urandom), 3'($urandom), 16'($urandom), 16'($urandom), 1'b0, 1'b0);
        checkOutput("contentionGrants", 64'(gntTimes.size()), 64'd4);
        for (int i = 1; i < gntTimes.size(); i++)
            checkOutput("contentionSpacing", 64'(gntTimes[i] - gntTimes[i-1]), 64'd3);
        applyStimulus(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 3'd0, 16'h0, 16'h0, 1'b0, 1'b0);

        $display("[TB] directed single accesses");
        applyStimulus(1'b1, 1'b1, 3'b001, 16'h3155, 1'b0, 1'b0, 3'd0, 16'h0, 16'hBEEF, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 1'b0, 3'b100, 16'h1234, 16'h02A7, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 3'b110, 16'hA5A5, 1'b0, 1'b0, 3'd0, 16'h0, 16'h7777, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 1'b0, 3'b111, 16'h0, 16'h5A5A, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 3'b101, 16'h0, 1'b0, 1'b0, 3'd0, 16'h0, 16'hC0DE, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 3'b010, 16'h4242, 1'b0, 1'b0, 3'd0, 16'h0, 16'h9999, 1'b1, 1'b0);

        $display("[TB] reset during access");
        applyStimulus(1'b1, 1'b1, 3'b011, 16'h1111, 1'b1, 1'b0, 3'b000, 16'h0, 16'h2222, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 3'd0, 16'h0, 16'h0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 3'b000, 16'h0F0F, 1'b1, 1'b1, 3'b001, 16'hF0F0, 16'h0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 3'd0, 16'h0, 16'h0, 1'b0, 1'b0);

        $display("[TB] random traffic");
        for (int i = 0; i < 200; i++)
            applyStimulus($urandom_range(0, 2) != 0, 1'($urandom), 3'($urandom), 16'($urandom),
                          $urandom_range(0, 2) != 0, 1'($urandom), 3'($urandom), 16'($urandom),
                          16'($urandom), 1'($urandom), 1'b0);
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 3'd0, 16'h0, 16'h0, 1'b0, 1'b0);

        $display("[TB] fixed priority instance");
        fp.m0_req_i = 1'b1; fp.m1_req_i = 1'b1;
        fp.m0_wr_i = 1'b1; fp.m0_addr_i = 3'b001; fp.m0_wdata_i = 16'h1111;
        fp.m1_wr_i = 1'b0; fp.m1_addr_i = 3'b010;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (fp.m0_gnt_o) fpGrants++;
            checkOutput("fpNoM1Grant", {63'd0, fp.m1_gnt_o}, 64'd0);
        end
        fp.m0_req_i = 1'b0; fp.m1_req_i = 1'b0;
        checkOutput("fpGrantCount", 64'(fpGrants), 64'd4);

        repeat (4) @(posedge clk);
        #1;
        checkOutput("scoreboardDrained", 64'(gntQ.size()), 64'd0);
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
